start_sequencer: RTL and testbench

- On-chip initiator for the program Start/Done handshake. Drives the Start line that the program counter's edge detector consumes, and runs programs 1..NPROG in series.
- For each program it pulses Start, waits for the core's Done, records the cycle count, then enforces a gap before the next Start.
- Sits between the top-level run control (Go input) and the core, in place of the test bench's Start sequencing.

---
 rtl/start_sequencer_pkg.sv | 6 +
 rtl/start_sequencer_if.sv | 17 +
 rtl/start_sequencer_edge_det.sv | 16 +
 rtl/start_sequencer.sv | 130 +++++++++++++
 tb/tb_start_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/start_sequencer_pkg.sv
// start_seq_pkg: shared state encoding and field widths for the start sequencer.
package start_seq_pkg;
    typedef enum logic [2:0] {IDLE, PULSE, RUN, GAP, FINISH} seq_state_t;
    localparam int IDX_W = 2;
    localparam int CNT_W = 16;
endpackage

// File: rtl/start_sequencer_if.sv
// start_sequencer_if: run-control and core handshake bundle.
// master: Go/Done in; Start, ProgIdx, Busy, ResultValid, ResultIdx, CycleCount, TimedOut, AllDone out.
// slave: the mirror view for the core / run control side.
interface start_sequencer_if #(parameter int CW = 16) ();
    import start_seq_pkg::*;
    logic Go, Done, Start, Busy, ResultValid, TimedOut, AllDone;
    logic [IDX_W-1:0] ProgIdx, ResultIdx;
    logic [CW-1:0] CycleCount;
    modport master (
        input Go, Done,
        output Start, ProgIdx, Busy, ResultValid, ResultIdx, CycleCount, TimedOut, AllDone
    );
    modport slave (
        output Go, Done,
        input Start, ProgIdx, Busy, ResultValid, ResultIdx, CycleCount, TimedOut, AllDone
    );
endinterface

// File: rtl/start_sequencer_edge_det.sv
// edge_det: registered 1-bit rising-edge detector.
// Ports: Clk, Reset (sync, active-low), d (level in), rise (d high now, low last cycle).
module edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic rise
);
    logic prev_q, prev_d;
    always_comb prev_d = d;
    always_ff @(posedge Clk) begin
        if (!Reset) prev_q <= 1'b0;
        else prev_q <= prev_d;
    end
    assign rise = d & ~prev_q;
endmodule

// File: rtl/start_sequencer.sv
// start_sequencer: pulses Start for programs 1..NPROG in series, times each run, enforces Done-low gaps.
// Ports: Clk, Reset (sync, active-low), bus (master view: Go/Done in; Start, ProgIdx, Busy,
// ResultValid, ResultIdx, CycleCount, TimedOut, AllDone out).
module start_sequencer
    import start_seq_pkg::*;
#(
    parameter int NPROG = 3,
    parameter int START_W = 2,
    parameter int GAP = 4,
    parameter int CW = CNT_W,
    parameter logic [CW-1:0] TIMEOUT = 16'hFFFF
) (
    input logic Clk,
    input logic Reset,
    start_sequencer_if.master bus
);
    localparam int PW = $clog2(START_W + 1);
    localparam int GW = $clog2(GAP + 1);
    seq_state_t state_q, state_d;
    logic [IDX_W-1:0] prog_idx_q, prog_idx_d, result_idx_q, result_idx_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d, cycle_count_q, cycle_count_d;
    logic start_q, start_d, result_valid_q, result_valid_d;
    logic timed_out_q, timed_out_d, all_done_q, all_done_d;
    logic done_rise;

    edge_det u_done_edge (.Clk(Clk), .Reset(Reset), .d(bus.Done), .rise(done_rise));

    always_comb begin
        state_d = state_q;
        prog_idx_d = prog_idx_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_cnt_d = gap_cnt_q;
        run_cnt_d = run_cnt_q;
        result_valid_d = 1'b0;
        result_idx_d = result_idx_q;
        cycle_count_d = cycle_count_q;
        timed_out_d = timed_out_q;
        all_done_d = all_done_q;
        case (state_q)
            IDLE: if (bus.Go) begin
                state_d = PULSE;
                prog_idx_d = IDX_W'(1);
                pulse_cnt_d = '0;
                timed_out_d = 1'b0;
                all_done_d = 1'b0;
            end
            PULSE: if (pulse_cnt_q == PW'(START_W - 1)) begin
                state_d = RUN;
                run_cnt_d = '0;
            end else begin
                pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
            RUN: begin
                run_cnt_d = (run_cnt_q == TIMEOUT) ? run_cnt_q : run_cnt_q + 1'b1;
                // A Done rise on the last allowed cycle still counts as a normal completion.
                if (done_rise) begin
                    state_d = start_seq_pkg::GAP;
                    gap_cnt_d = '0;
                    result_valid_d = 1'b1;
                    result_idx_d = prog_idx_q;
                    cycle_count_d = run_cnt_q;
                end else if (run_cnt_q == TIMEOUT - 1'b1) begin
                    state_d = FINISH;
                    timed_out_d = 1'b1;
                    all_done_d = 1'b1;
                    result_valid_d = 1'b1;
                    result_idx_d = prog_idx_q;
                    cycle_count_d = TIMEOUT;
                end
            end
            start_seq_pkg::GAP: if (bus.Done) begin
                gap_cnt_d = '0;
            end else if (gap_cnt_q == GW'(GAP - 1)) begin
                state_d = (prog_idx_q == IDX_W'(NPROG)) ? FINISH : PULSE;
                all_done_d = (prog_idx_q == IDX_W'(NPROG));
                prog_idx_d = (prog_idx_q == IDX_W'(NPROG)) ? prog_idx_q : prog_idx_q + 1'b1;
                pulse_cnt_d = '0;
            end else begin
                gap_cnt_d = gap_cnt_q + 1'b1;
            end
            FINISH: if (!bus.Go) begin
                state_d = IDLE;
                prog_idx_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Start is a pure register: high exactly while the next state is PULSE.
    always_comb start_d = (state_d == PULSE);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            prog_idx_q <= '0;
            pulse_cnt_q <= '0;
            gap_cnt_q <= '0;
            run_cnt_q <= '0;
            result_valid_q <= 1'b0;
            result_idx_q <= '0;
            cycle_count_q <= '0;
            timed_out_q <= 1'b0;
            all_done_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_idx_q <= prog_idx_d;
            pulse_cnt_q <= pulse_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            run_cnt_q <= run_cnt_d;
            result_valid_q <= result_valid_d;
            result_idx_q <= result_idx_d;
            cycle_count_q <= cycle_count_d;
            timed_out_q <= timed_out_d;
            all_done_q <= all_done_d;
            start_q <= start_d;
        end
    end

    assign bus.Start = start_q;
    assign bus.ProgIdx = prog_idx_q;
    assign bus.Busy = (state_q != IDLE) && (state_q != FINISH);
    assign bus.ResultValid = result_valid_q;
    assign bus.ResultIdx = result_idx_q;
    assign bus.CycleCount = cycle_count_q;
    assign bus.TimedOut = timed_out_q;
    assign bus.AllDone = all_done_q;
endmodule

// File: tb/tb_start_sequencer.sv
// tb_start_sequencer: table-driven series plus hand-written corner sequences with a result scoreboard.
module tb_start_sequencer;
    localparam int GAP_C = 4;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    start_sequencer_if #(.CW(16)) bus ();
    start_sequencer #(.NPROG(3), .START_W(2), .GAP(GAP_C), .CW(16), .TIMEOUT(16'd50)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );

    typedef struct { int delay; int hold; bit poke; int idx; int cnt; } vec_t;
    typedef struct { int idx; int cnt; } exp_t;
    vec_t vecs [6];
    exp_t exp_q [$];
    int checks = 0, failures = 0, cyc = 0, falls = 0, rises = 0, done_low = 0, rise_cyc = 0;
    logic start_prev = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance one cycle and run the scoreboard/monitor on the fresh outputs.
    task automatic tick();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        done_low = bus.Done ? 0 : done_low + 1;
        if (bus.Start && !start_prev) begin
            rises++;
            rise_cyc = cyc;
            if (bus.ProgIdx > 2'd1) chk("gap_done_low", done_low >= GAP_C, 1);
        end
        if (!bus.Start && start_prev) falls++;
        start_prev = bus.Start;
        if (bus.ResultValid) begin
            chk("result_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result_idx", bus.ResultIdx, e.idx);
                chk("cycle_count", bus.CycleCount, e.cnt);
            end
        end
    endtask

    task automatic wait_falls(int target);
        for (int n = 0; n < 300 && falls < target; n++) tick();
        chk("start_fall_seen", falls >= target, 1);
    endtask

    task automatic wait_rise(int target);
        for (int n = 0; n < 300 && rises < target; n++) tick();
        chk("start_rise_seen", rises >= target, 1);
    endtask

    task automatic wait_all_done();
        for (int n = 0; n < 300 && !bus.AllDone; n++) tick();
        chk("all_done", bus.AllDone, 1);
    endtask

    // Accept Go and check the START_W=2 pulse; returns in the first RUN cycle.
    task automatic go_start(bit hold);
        bus.Go = 1'b1;
        tick();
        chk("go_start", bus.Start, 1);
        chk("go_prog_idx", bus.ProgIdx, 1);
        chk("go_busy", bus.Busy, 1);
        chk("go_all_done_clr", bus.AllDone, 0);
        chk("go_timed_out_clr", bus.TimedOut, 0);
        if (!hold) bus.Go = 1'b0;
        tick();
        chk("start_second", bus.Start, 1);
        tick();
        chk("start_low_run", bus.Start, 0);
    endtask

    task automatic run_series(int lo, bit hold);
        int f0;
        vec_t v;
        f0 = falls;
        go_start(hold);
        for (int k = 0; k < 3; k++) begin
            v = vecs[lo + k];
            wait_falls(f0 + k + 1);
            if (v.poke) begin
                bus.Go = 1'b1;
                tick();
                bus.Go = 1'b0;
                tick();
                chk("poke_prog_idx", bus.ProgIdx, v.idx);
                chk("poke_start", bus.Start, 0);
                repeat (v.delay - 2) tick();
            end else begin
                repeat (v.delay) tick();
            end
            exp_q.push_back(exp_t'{v.idx, v.cnt});
            bus.Done = 1'b1;
            repeat (v.hold) tick();
            bus.Done = 1'b0;
        end
        wait_all_done();
        chk("series_timed_out", bus.TimedOut, 0);
        chk("series_prog_idx", bus.ProgIdx, 3);
        chk("series_busy", bus.Busy, 0);
        chk("series_drained", exp_q.size(), 0);
    endtask

    initial begin
        int f0, r0, last_hi;
        vecs = '{'{20, 3, 1'b0, 1, 20}, '{20, 3, 1'b1, 2, 20}, '{20, 3, 1'b0, 3, 20},
                 '{0, 1, 1'b0, 1, 0}, '{49, 2, 1'b0, 2, 49}, '{7, 3, 1'b0, 3, 7}};
        bus.Go = 1'b0;
        bus.Done = 1'b0;
        repeat (3) tick();
        chk("rst_start", bus.Start, 0);
        chk("rst_prog_idx", bus.ProgIdx, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_all_done", bus.AllDone, 0);
        chk("rst_timed_out", bus.TimedOut, 0);
        chk("rst_valid", bus.ResultValid, 0);
        chk("rst_cycle_count", bus.CycleCount, 0);
        Reset = 1'b1;
        while (cyc < 10) tick();
        run_series(0, 1'b0);
        tick();
        chk("finish_idle_prog", bus.ProgIdx, 0);
        chk("finish_all_done_held", bus.AllDone, 1);
        run_series(3, 1'b1);
        r0 = rises;
        repeat (10) tick();
        chk("held_go_all_done", bus.AllDone, 1);
        chk("held_go_prog", bus.ProgIdx, 3);
        chk("held_go_no_restart", rises, r0);
        bus.Go = 1'b0;
        tick();
        chk("held_go_release_prog", bus.ProgIdx, 0);
        chk("held_go_release_done", bus.AllDone, 1);
        f0 = falls;
        go_start(1'b0);
        repeat (3) tick();
        exp_q.push_back(exp_t'{1, 3});
        bus.Done = 1'b1;
        repeat (31) tick();
        bus.Done = 1'b0;
        last_hi = cyc - 1;
        wait_rise(rises + 1);
        chk("stuck_gap_delay", rise_cyc - last_hi, GAP_C + 1);
        wait_falls(f0 + 2);
        repeat (2) tick();
        exp_q.push_back(exp_t'{2, 2});
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        repeat (2) tick();
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        last_hi = cyc - 1;
        wait_rise(rises + 1);
        chk("chatter_gap_delay", rise_cyc - last_hi, GAP_C + 1);
        wait_falls(f0 + 3);
        repeat (4) tick();
        exp_q.push_back(exp_t'{3, 4});
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        wait_all_done();
        tick();
        exp_q.push_back(exp_t'{1, 50});
        go_start(1'b0);
        wait_all_done();
        chk("to_timed_out", bus.TimedOut, 1);
        chk("to_prog_idx", bus.ProgIdx, 1);
        chk("to_busy", bus.Busy, 0);
        chk("to_drained", exp_q.size(), 0);
        r0 = rises;
        repeat (20) tick();
        chk("to_no_more_start", rises, r0);
        chk("to_idle_prog", bus.ProgIdx, 0);
        chk("to_sticky", bus.TimedOut, 1);
        bus.Done = 1'b1;
        repeat (2) tick();
        f0 = falls;
        go_start(1'b0);
        repeat (5) tick();
        bus.Done = 1'b0;
        repeat (7) tick();
        exp_q.push_back(exp_t'{1, 12});
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        wait_falls(f0 + 2);
        repeat (5) tick();
        chk("pre_reset_prog", bus.ProgIdx, 2);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk("mid_rst_start", bus.Start, 0);
        chk("mid_rst_prog", bus.ProgIdx, 0);
        chk("mid_rst_count", bus.CycleCount, 0);
        chk("mid_rst_timed_out", bus.TimedOut, 0);
        chk("mid_rst_all_done", bus.AllDone, 0);
        chk("mid_rst_busy", bus.Busy, 0);
        chk("stale_single_result", exp_q.size(), 0);
        tick();
        chk("idle_after_rst", bus.Busy, 0);
        go_start(1'b0);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
